// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception controller: records cause/EPC and redirects the PC through a memory vector
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   bad_opcode          decoder saw a nonexistent opcode this cycle
//   overflow            ALU signed overflow this cycle
//   div_zero            divider saw a zero divisor this cycle
//   PC_in[31:0]         current PC (already advanced by 4)
//   exc_mem_addr[31:0]  vector address for the memory address mux
//   exc_mem_sel         memory address mux takes exc_mem_addr
//   EPC[31:0]           saved exception PC
//   cause[1:0]          latched cause: 01 opcode, 10 overflow, 11 div-by-zero, 00 none
//   EX_control          PC source select to the exception mux (memory data)
//   exc_PC_write        forces a PC register write
//   stall               holds the main control unit while a sequence runs
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        bad_opcode,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic [31:0] PC_in,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_sel,
    output logic [31:0] EPC,
    output logic [1:0]  cause,
    output logic        EX_control,
    output logic        exc_PC_write,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        any_flag;
    logic [1:0]  cause_new;

    assign any_flag = bad_opcode | overflow | div_zero;

    // Fixed priority: only the highest-ranked flag is recorded.
    always_comb begin
        cause_new = 2'b00;
        if (bad_opcode)
            cause_new = 2'b01;
        else if (overflow)
            cause_new = 2'b10;
        else if (div_zero)
            cause_new = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            EPC   <= 32'd0;
            cause <= 2'b00;
        end else begin
            state <= state_next;
            // Flags are only accepted from IDLE; anything seen mid-sequence is dropped.
            if (state == IDLE && any_flag) begin
                EPC   <= PC_in - 32'd4;
                cause <= cause_new;
            end
        end
    end

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        exc_mem_sel  = 1'b0;
        EX_control   = 1'b0;
        exc_PC_write = 1'b0;
        case (state)
            IDLE: begin
                if (any_flag)
                    state_next = SAVE;
            end
            SAVE: begin
                stall       = 1'b1;
                exc_mem_sel = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                // Covers the one-cycle memory read latency of the vector fetch.
                stall       = 1'b1;
                exc_mem_sel = 1'b1;
                state_next  = LOAD;
            end
            LOAD: begin
                stall        = 1'b1;
                exc_mem_sel  = 1'b1;
                EX_control   = 1'b1;
                exc_PC_write = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Vector table lives at 253..255; cause 00 maps to address 0.
    always_comb begin
        exc_mem_addr = 32'd0;
        case (cause)
            2'b01:   exc_mem_addr = 32'd253;
            2'b10:   exc_mem_addr = 32'd254;
            2'b11:   exc_mem_addr = 32'd255;
            default: exc_mem_addr = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl with directed vectors
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        bad_opcode;
    logic        overflow;
    logic        div_zero;
    logic [31:0] PC_in;
    logic [31:0] exc_mem_addr;
    logic        exc_mem_sel;
    logic [31:0] EPC;
    logic [1:0]  cause;
    logic        EX_control;
    logic        exc_PC_write;
    logic        stall;

    exc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bad_opcode   (bad_opcode),
        .overflow     (overflow),
        .div_zero     (div_zero),
        .PC_in        (PC_in),
        .exc_mem_addr (exc_mem_addr),
        .exc_mem_sel  (exc_mem_sel),
        .EPC          (EPC),
        .cause        (cause),
        .EX_control   (EX_control),
        .exc_PC_write (exc_PC_write),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        stall;
        logic        ex_control;
        logic        pc_write;
        logic [31:0] addr;
        logic [31:0] epc;
        logic [1:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   applied   = 0;
    int   miscompare = 0;
    bit   stim_done = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscompare++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, req);
        end
    endtask

    // Inputs are driven 2 time units after a rising edge; the expected
    // state after the following edge is queued for the monitor.
    task automatic step(input int id, input logic rst, input logic bo, input logic ov, input logic dz,
                        input logic [31:0] pc, input logic e_stall, input logic e_ctl, input logic e_pcw,
                        input logic [31:0] e_addr, input logic [31:0] e_epc, input logic [1:0] e_cause);
        exp_t e;
        @(posedge clk);
        #2;
        reset      = rst;
        bad_opcode = bo;
        overflow   = ov;
        div_zero   = dz;
        PC_in      = pc;
        e.id = id; e.stall = e_stall; e.ex_control = e_ctl; e.pc_write = e_pcw;
        e.addr = e_addr; e.epc = e_epc; e.cause = e_cause;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",        e.id, {31'd0, stall},        {31'd0, e.stall});
                check("exc_mem_sel",  e.id, {31'd0, exc_mem_sel},  {31'd0, e.stall});
                check("EX_control",   e.id, {31'd0, EX_control},   {31'd0, e.ex_control});
                check("exc_PC_write", e.id, {31'd0, exc_PC_write}, {31'd0, e.pc_write});
                check("exc_mem_addr", e.id, exc_mem_addr,          e.addr);
                check("EPC",          e.id, EPC,                   e.epc);
                check("cause",        e.id, {30'd0, cause},        {30'd0, e.cause});
            end
        end
    end

    initial begin
        reset = 1'b1; bad_opcode = 1'b0; overflow = 1'b0; div_zero = 1'b0; PC_in = 32'd0;
        //       id rst bo ov dz  PC_in          stl ctl pcw addr  EPC            cause
        step( 1, 1, 0, 0, 0, 32'h0000_0010, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        step( 2, 0, 0, 0, 0, 32'h0000_0010, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        // single overflow
        step( 3, 0, 0, 1, 0, 32'h0000_0010, 1, 0, 0, 32'd254, 32'h0000_000C, 2'b10);
        step( 4, 0, 0, 0, 0, 32'h0000_0014, 1, 0, 0, 32'd254, 32'h0000_000C, 2'b10);
        step( 5, 0, 0, 0, 0, 32'h0000_0014, 1, 1, 1, 32'd254, 32'h0000_000C, 2'b10);
        step( 6, 0, 0, 0, 0, 32'h0000_0018, 0, 0, 0, 32'd254, 32'h0000_000C, 2'b10);
        // all three flags at once: opcode wins
        step( 7, 0, 1, 1, 1, 32'h0000_0020, 1, 0, 0, 32'd253, 32'h0000_001C, 2'b01);
        step( 8, 0, 0, 0, 0, 32'h0000_0024, 1, 0, 0, 32'd253, 32'h0000_001C, 2'b01);
        step( 9, 0, 0, 0, 0, 32'h0000_0024, 1, 1, 1, 32'd253, 32'h0000_001C, 2'b01);
        step(10, 0, 0, 0, 0, 32'h0000_0024, 0, 0, 0, 32'd253, 32'h0000_001C, 2'b01);
        // div_zero, then overflow mid-sequence is ignored
        step(11, 0, 0, 0, 1, 32'h0000_0030, 1, 0, 0, 32'd255, 32'h0000_002C, 2'b11);
        step(12, 0, 0, 1, 0, 32'h0000_0050, 1, 0, 0, 32'd255, 32'h0000_002C, 2'b11);
        step(13, 0, 0, 1, 0, 32'h0000_0050, 1, 1, 1, 32'd255, 32'h0000_002C, 2'b11);
        step(14, 0, 0, 0, 0, 32'h0000_0050, 0, 0, 0, 32'd255, 32'h0000_002C, 2'b11);
        step(15, 0, 0, 0, 0, 32'h0000_0050, 0, 0, 0, 32'd255, 32'h0000_002C, 2'b11);
        // PC_in = 0 wraps EPC
        step(16, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 0, 32'd255, 32'hFFFF_FFFC, 2'b11);
        step(17, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, 32'd255, 32'hFFFF_FFFC, 2'b11);
        step(18, 0, 0, 0, 0, 32'h0000_0000, 1, 1, 1, 32'd255, 32'hFFFF_FFFC, 2'b11);
        // flag held during LOAD is dropped, then taken in the first IDLE cycle
        step(19, 0, 0, 1, 0, 32'h0000_0040, 0, 0, 0, 32'd255, 32'hFFFF_FFFC, 2'b11);
        step(20, 0, 0, 1, 0, 32'h0000_0040, 1, 0, 0, 32'd254, 32'h0000_003C, 2'b10);
        step(21, 0, 0, 0, 0, 32'h0000_0044, 1, 0, 0, 32'd254, 32'h0000_003C, 2'b10);
        // reset during WAIT: no LOAD afterwards
        step(22, 1, 0, 0, 0, 32'h0000_0044, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        step(23, 0, 0, 0, 0, 32'h0000_0044, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        step(24, 0, 0, 0, 0, 32'h0000_0044, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        // reset has priority over flags
        step(25, 1, 1, 1, 1, 32'h0000_0080, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        step(26, 0, 0, 0, 0, 32'h0000_0080, 0, 0, 0, 32'd0,   32'h0000_0000, 2'b00);
        stim_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        #3;
        applied++;
        if (exp_q.size() != 0 || !stim_done) begin
            miscompare++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompare);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 Port clk: input, 1 bit, system clock.
REQ-003 Port reset: input, 1 bit, synchronous active-high reset.
REQ-004 Port bad_opcode: input, 1 bit, decoder flags a nonexistent opcode this cycle.
REQ-005 Port overflow: input, 1 bit, ALU signed overflow flag this cycle.
REQ-006 Port div_zero: input, 1 bit, divider flags a zero divisor this cycle.
REQ-007 Port PC_in: input, 32 bits, current PC register value (already incremented by 4).
REQ-008 Port exc_mem_addr: output, 32 bits, vector address driven to the memory address mux.
REQ-009 Port exc_mem_sel: output, 1 bit, 1 = memory address mux takes exc_mem_addr.
REQ-010 Port EPC: output, 32 bits, saved exception PC.
REQ-011 Port cause: output, 2 bits, latched cause: 01 opcode, 10 overflow, 11 div-by-zero, 00 none.
REQ-012 Port EX_control: output, 1 bit, PC-source select to the exception mux (1 = memory data).
REQ-013 Port exc_PC_write: output, 1 bit, forces a PC register write.
REQ-014 Port stall: output, 1 bit, holds the main control unit while the block is busy.

Function
REQ-015 The FSM SHALL have four states: IDLE, SAVE, WAIT, LOAD; all outputs except EPC and cause SHALL be decoded from state only (Moore).
REQ-016 In IDLE, if any flag is 1 at a rising edge, the FSM SHALL go to SAVE, latch cause, and latch EPC <= PC_in - 4 (32-bit wrap-around, e.g. PC_in=0 gives 0xFFFFFFFC).
REQ-017 Simultaneous flags SHALL be prioritised bad_opcode > overflow > div_zero; only the winner is recorded.
REQ-018 Vector addresses SHALL be 253 (cause 01), 254 (cause 10), and 255 (cause 11), zero-extended to 32 bits; exc_mem_addr SHALL be 0 when cause = 00.
REQ-019 SAVE: stall=1, exc_mem_sel=1; the next state SHALL be WAIT.
REQ-020 WAIT: stall=1, exc_mem_sel=1, covering the one-cycle memory read latency; the next state SHALL be LOAD.
REQ-021 LOAD: stall=1, exc_mem_sel=1, EX_control=1, exc_PC_write=1, so the PC loads the memory data through the exception mux; the next state SHALL be IDLE.
REQ-022 In IDLE, stall, exc_mem_sel, EX_control, and exc_PC_write SHALL be 0.
REQ-023 The full sequence SHALL take exactly 3 cycles from the flag edge to IDLE; the PC update occurs at the LOAD-to-IDLE edge.
REQ-024 Flags asserted in SAVE, WAIT, or LOAD SHALL be ignored and not queued; EPC and cause SHALL hold.
REQ-025 A flag asserted in the first IDLE cycle after LOAD SHALL start a new sequence and overwrite EPC and cause.
REQ-026 EPC and cause SHALL hold their values in IDLE until the next accepted exception.

Reset
REQ-027 When reset=1 at an edge, the FSM SHALL go to IDLE, and EPC and cause SHALL be cleared to 0; this takes priority over every flag and over any state, including mid-sequence.
REQ-028 If reset is asserted during WAIT, exc_PC_write SHALL NOT be asserted afterwards, and no PC load occurs.
REQ-029 In the cycle after reset, all outputs SHALL be 0, and exc_mem_addr SHALL be 0.

Verification
REQ-030 overflow=1 for one cycle with PC_in=0x00000010 -> EPC=0x0000000C, cause=10, exc_mem_addr=254 during SAVE/WAIT/LOAD, EX_control=1 and exc_PC_write=1 in LOAD only, stall high for exactly 3 cycles.
REQ-031 bad_opcode=1, overflow=1, and div_zero=1 in the same cycle -> cause=01 and exc_mem_addr=253.
REQ-032 div_zero=1 at the edge entering SAVE, then overflow=1 during WAIT -> cause stays 11, EPC unchanged, and only one LOAD occurs.
REQ-033 Reset asserted during WAIT -> next cycle IDLE with EPC=0, cause=00, and exc_PC_write never asserted.
REQ-034 PC_in=0x00000000 with div_zero=1 -> EPC=0xFFFFFFFC and exc_mem_addr=255.
REQ-035 overflow=1 in the IDLE cycle immediately after LOAD, with PC_in=0x00000040 -> a second sequence starts, with EPC=0x0000003C and cause=10.
